// File: rtl/linescanner_capture_controller.sv
// Line-scanner capture sequencer: arms on start, aligns to line sync,
// gates the packing convertor, counts pixels/lines and reports status.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   start, abort        software control pulses
//   pixels_per_line     frame width, latched at start
//   lines_per_frame     frame height, latched at start
//   line_sync           scanner start-of-line strobe
//   pixel_strobe        scanner pixel-valid strobe
//   stream_ready        downstream can accept data
//   conv_enable         convertor enable (LINE only)
//   line_last           current strobe would be last pixel of line
//   frame_last          current strobe would be last pixel of frame
//   busy, done, error   status; err_code 1=timeout 2=overflow 3=zero geom
//   pixel_cnt, line_cnt position within the frame
module linescanner_capture_controller #(
  parameter int PIX_W   = 12,
  parameter int LINE_W  = 12,
  parameter int TIMEOUT = 1000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [PIX_W-1:0]  pixels_per_line,
  input  logic [LINE_W-1:0] lines_per_frame,
  input  logic              line_sync,
  input  logic              pixel_strobe,
  input  logic              stream_ready,
  output logic              conv_enable,
  output logic              line_last,
  output logic              frame_last,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code,
  output logic [PIX_W-1:0]  pixel_cnt,
  output logic [LINE_W-1:0] line_cnt
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_LINE,
    S_GAP,
    S_DONE,
    S_ERR
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [1:0]        code_q;
  logic [1:0]        code_nx;
  logic [PIX_W-1:0]  ppl_q;
  logic [LINE_W-1:0] lpf_q;
  logic [TW-1:0]     tmo_q;

  logic geo_zero;
  logic tmo_hit;
  logic pix_ok;
  logic ovf;
  logic in_line;
  logic ll;
  logic fl;

  assign geo_zero = (pixels_per_line == '0)
                 || (lines_per_frame == '0);
  assign tmo_hit  = (tmo_q == TW'(TIMEOUT - 1));
  assign pix_ok   = pixel_strobe && stream_ready;
  assign ovf      = pixel_strobe && !stream_ready;
  assign in_line  = (state == S_LINE);
  assign ll       = in_line
                 && (pixel_cnt == ppl_q - PIX_W'(1));
  assign fl       = ll
                 && (line_cnt == lpf_q - LINE_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      code_q <= 2'd0;
    end else begin
      state  <= state_nx;
      code_q <= code_nx;
    end
  end

  always_comb begin
    state_nx = state;
    code_nx  = code_q;
    if (abort) begin
      state_nx = S_IDLE;
      code_nx  = 2'd0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            if (geo_zero) begin
              state_nx = S_ERR;
              code_nx  = 2'd3;
            end else begin
              state_nx = S_ARM;
            end
          end
        end
        S_ARM, S_GAP: begin
          if (line_sync) begin
            state_nx = S_LINE;
          end else if (tmo_hit) begin
            state_nx = S_ERR;
            code_nx  = 2'd1;
          end
        end
        S_LINE: begin
          if (ovf) begin
            state_nx = S_ERR;
            code_nx  = 2'd2;
          end else if (pix_ok && ll) begin
            state_nx = fl ? S_DONE : S_GAP;
          end
        end
        S_DONE:  state_nx = S_IDLE;
        S_ERR:   state_nx = S_ERR;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_comb begin
    conv_enable = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    error       = 1'b0;
    unique case (state)
      S_ARM:   busy = 1'b1;
      S_GAP:   busy = 1'b1;
      S_LINE: begin
        busy        = 1'b1;
        conv_enable = 1'b1;
      end
      S_DONE:  done  = 1'b1;
      S_ERR:   error = 1'b1;
      default: ;
    endcase
    err_code   = code_q;
    line_last  = ll;
    frame_last = fl;
  end

  // Counters, wait timer and latched geometry.
  // A stalled pixel (overflow) is never counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ppl_q     <= '0;
      lpf_q     <= '0;
      tmo_q     <= '0;
      pixel_cnt <= '0;
      line_cnt  <= '0;
    end else if (abort) begin
      tmo_q     <= '0;
      pixel_cnt <= '0;
      line_cnt  <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          tmo_q <= '0;
          if (start) begin
            ppl_q     <= pixels_per_line;
            lpf_q     <= lines_per_frame;
            pixel_cnt <= '0;
            line_cnt  <= '0;
          end
        end
        S_ARM, S_GAP: begin
          if (line_sync || tmo_hit) begin
            tmo_q <= '0;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        S_LINE: begin
          tmo_q <= '0;
          if (pix_ok) begin
            if (ll) begin
              pixel_cnt <= '0;
              if (!fl) begin
                line_cnt <= line_cnt + LINE_W'(1);
              end
            end else begin
              pixel_cnt <= pixel_cnt + PIX_W'(1);
            end
          end
        end
        default: tmo_q <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_linescanner_capture_controller.sv
// Bench for linescanner_capture_controller: directed table,
// corner-case sequences and random traffic against a frame model.
module tb_linescanner_capture_controller;

  localparam int PW  = 12;
  localparam int LW  = 12;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          line_sync = 1'b0;
  logic          pixel_strobe = 1'b0;
  logic          stream_ready = 1'b1;
  logic [PW-1:0] ppl_in = '0;
  logic [LW-1:0] lpf_in = '0;
  logic          conv_enable;
  logic          line_last;
  logic          frame_last;
  logic          busy;
  logic          done;
  logic          error;
  logic [1:0]    err_code;
  logic [PW-1:0] pixel_cnt;
  logic [LW-1:0] line_cnt;

  linescanner_capture_controller #(
    .PIX_W(PW), .LINE_W(LW), .TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .abort(abort),
    .pixels_per_line(ppl_in),
    .lines_per_frame(lpf_in),
    .line_sync(line_sync),
    .pixel_strobe(pixel_strobe),
    .stream_ready(stream_ready),
    .conv_enable(conv_enable),
    .line_last(line_last),
    .frame_last(frame_last),
    .busy(busy),
    .done(done),
    .error(error),
    .err_code(err_code),
    .pixel_cnt(pixel_cnt),
    .line_cnt(line_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // {busy,conv,ll,fl,done,error,code,pix,line}
  function automatic logic [31:0] pk(
    bit b, bit c, bit ll, bit fl, bit d, bit e,
    int code, int pix, int ln);
    return {b, c, ll, fl, d, e, 2'(code),
            12'(pix), 12'(ln)};
  endfunction

  function automatic logic [31:0] act();
    return {busy, conv_enable, line_last, frame_last,
            done, error, err_code, pixel_cnt, line_cnt};
  endfunction

  task automatic check(string nm, logic [31:0] exp);
    logic [31:0] a;
    a = act();
    n_vec++;
    if (a !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, a, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(bit st, bit ab, bit sy,
                       bit sb, bit rdy);
    start        = st;
    abort        = ab;
    line_sync    = sy;
    pixel_strobe = sb;
    stream_ready = rdy;
    tick();
  endtask

  // Frame model: tracks total accepted pixels of the frame
  // and derives position from it arithmetically.
  bit         m_wait, m_line, m_done, m_err;
  logic [1:0] m_code;
  int         m_wc, m_tot, m_ppl, m_lpf;

  task automatic m_reset();
    m_wait = 0; m_line = 0; m_done = 0; m_err = 0;
    m_code = 0; m_wc = 0; m_tot = 0;
    m_ppl = 0; m_lpf = 0;
  endtask

  task automatic m_step(bit st, bit ab, bit sy, bit sb,
                        bit rdy, int p, int l);
    if (ab) begin
      m_wait = 0; m_line = 0; m_done = 0; m_err = 0;
      m_code = 0; m_tot = 0; m_wc = 0;
    end else if (m_err) begin
      m_err = 1;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_wait) begin
      if (sy) begin
        m_wait = 0;
        m_line = 1;
      end else if (m_wc == TMO - 1) begin
        m_wait = 0;
        m_err  = 1;
        m_code = 1;
      end else begin
        m_wc++;
      end
    end else if (m_line) begin
      if (sb && !rdy) begin
        m_line = 0;
        m_err  = 1;
        m_code = 2;
      end else if (sb) begin
        m_tot++;
        if (m_tot % m_ppl == 0) begin
          m_line = 0;
          if (m_tot == m_ppl * m_lpf) m_done = 1;
          else begin
            m_wait = 1;
            m_wc   = 0;
          end
        end
      end
    end else if (st) begin
      m_ppl = p;
      m_lpf = l;
      m_tot = 0;
      if (p == 0 || l == 0) begin
        m_err  = 1;
        m_code = 3;
      end else begin
        m_wait = 1;
        m_wc   = 0;
      end
    end
  endtask

  function automatic logic [31:0] m_exp();
    int pix, ln, lnr;
    bit ll, fl;
    pix = 0; ln = 0; lnr = 0;
    if (m_ppl != 0 && m_lpf != 0) begin
      pix = m_tot % m_ppl;
      lnr = m_tot / m_ppl;
      ln  = (lnr > m_lpf - 1) ? m_lpf - 1 : lnr;
    end
    ll = m_line && (pix == m_ppl - 1);
    fl = ll && (lnr == m_lpf - 1);
    return pk(m_wait || m_line, m_line, ll, fl,
              m_done, m_err, int'(m_code), pix, ln);
  endfunction

  typedef struct {
    bit          st;
    bit          sy;
    bit          sb;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{1, 0, 0, pk(1,0,0,0,0,0,0,0,0)};
    tbl[1]  = '{0, 1, 0, pk(1,1,0,0,0,0,0,0,0)};
    tbl[2]  = '{0, 0, 1, pk(1,1,0,0,0,0,0,1,0)};
    tbl[3]  = '{0, 0, 1, pk(1,1,0,0,0,0,0,2,0)};
    tbl[4]  = '{0, 0, 1, pk(1,1,1,0,0,0,0,3,0)};
    tbl[5]  = '{0, 0, 1, pk(1,0,0,0,0,0,0,0,1)};
    tbl[6]  = '{0, 1, 0, pk(1,1,0,0,0,0,0,0,1)};
    tbl[7]  = '{0, 0, 1, pk(1,1,0,0,0,0,0,1,1)};
    tbl[8]  = '{0, 0, 1, pk(1,1,0,0,0,0,0,2,1)};
    tbl[9]  = '{0, 0, 1, pk(1,1,1,1,0,0,0,3,1)};
    tbl[10] = '{0, 0, 1, pk(0,0,0,0,1,0,0,0,1)};
    tbl[11] = '{0, 0, 0, pk(0,0,0,0,0,0,0,0,1)};

    #12;
    check("in_reset", 32'd0);
    rst_n = 1'b1;
    tick();
    check("after_reset", 32'd0);

    // Two-line frame, 4 pixels per line.
    ppl_in = 12'd4;
    lpf_in = 12'd2;
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].st, 0, tbl[i].sy, tbl[i].sb, 1);
      check($sformatf("tbl%0d", i), tbl[i].exp);
    end

    // Zero geometry.
    ppl_in = 12'd0;
    drive(1, 0, 0, 0, 1);
    check("zero_geo", pk(0,0,0,0,0,1,3,0,0));
    drive(1, 0, 1, 1, 1);
    check("zero_geo_hold", pk(0,0,0,0,0,1,3,0,0));
    drive(0, 1, 0, 0, 1);
    check("zero_geo_abort", 32'd0);

    // Sync timeout: 16 cycles in ARM.
    ppl_in = 12'd4;
    drive(1, 0, 0, 0, 1);
    check("tmo_arm", pk(1,0,0,0,0,0,0,0,0));
    for (int i = 0; i < 14; i++) drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 1, 1);
    check("tmo_edge", pk(1,0,0,0,0,0,0,0,0));
    drive(0, 0, 0, 0, 1);
    check("tmo_err", pk(0,0,0,0,0,1,1,0,0));
    drive(0, 1, 0, 0, 1);
    check("tmo_abort", 32'd0);

    // Overflow at pixel 3.
    ppl_in = 12'd8;
    drive(1, 0, 0, 0, 1);
    drive(0, 0, 1, 0, 1);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 1);
    check("ovf_pre", pk(1,1,0,0,0,0,0,3,0));
    drive(0, 0, 0, 1, 0);
    check("ovf_err", pk(0,0,0,0,0,1,2,3,0));
    drive(0, 1, 0, 0, 1);

    // Abort on the last strobe of the frame.
    ppl_in = 12'd2;
    lpf_in = 12'd1;
    drive(1, 0, 0, 0, 1);
    drive(0, 0, 1, 0, 1);
    drive(0, 0, 0, 1, 1);
    check("abt_last", pk(1,1,1,1,0,0,0,1,0));
    drive(0, 1, 0, 1, 1);
    check("abt_idle", 32'd0);
    drive(0, 0, 0, 0, 1);
    check("abt_nodone", 32'd0);

    // Async reset mid-line.
    ppl_in = 12'd4;
    lpf_in = 12'd2;
    drive(1, 0, 0, 0, 1);
    drive(0, 0, 1, 0, 1);
    drive(0, 0, 0, 1, 1);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst", 32'd0);
    #2;
    rst_n = 1'b1;
    drive(1, 0, 0, 0, 1);
    check("rst_restart", pk(1,0,0,0,0,0,0,0,0));

    // Random traffic against the frame model.
    drive(0, 0, 0, 0, 1);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    m_reset();
    for (int i = 0; i < 3000; i++) begin
      bit st, ab, sy, sb, rdy;
      int p, l;
      st  = ($urandom_range(0, 3) == 0);
      ab  = ($urandom_range(0, 39) == 0);
      sy  = ($urandom_range(0, 5) == 0);
      sb  = ($urandom_range(0, 2) != 0);
      rdy = ($urandom_range(0, 29) != 0);
      p   = ($urandom_range(0, 12) == 0) ? 0
          : int'($urandom_range(1, 5));
      l   = ($urandom_range(0, 12) == 0) ? 0
          : int'($urandom_range(1, 3));
      ppl_in = PW'(p);
      lpf_in = LW'(l);
      m_step(st, ab, sy, sb, rdy, p, l);
      drive(st, ab, sy, sb, rdy);
      check($sformatf("rand%0d", i), m_exp());
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
